bsg_manycore_block_mem: RTL and testbench

Single-port, byte-maskable word memory that executes the block-mem packets produced by the manycore link-to-block-mem adapter.
- Performs word, halfword and byte loads (signed/unsigned) and masked stores.
- Load data returns exactly one cycle after the request.
- Sits directly downstream of the adapter; its data_o drives the adapter's load/AMO data input.

---
 rtl/block_mem_pkg.sv | 42 ++++
 rtl/bsg_manycore_block_mem_load_align.sv | 39 +++
 rtl/bsg_mem_1rw_sync_mask_write_byte.sv | 44 ++++
 rtl/bsg_manycore_block_mem.sv | 116 +++++++++++
 tb/tb_bsg_manycore_block_mem.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/block_mem_pkg.sv
// block_mem_pkg: shared opcode enum, sizing helper and packet macros for the
// manycore block-mem path (adapter and memory both compile against this).
//   block_mem_opcode_e       : operation carried in a block-mem packet
//   safe_clog2               : clog2 that never returns 0 (1-entry arrays still get a bit)
//   `BLOCK_MEM_PKT_WIDTH     : packet width for a given byte-address/data width
//   `DECLARE_BLOCK_MEM_PKT_S : packed packet struct {opcode, addr, data, mask}
`ifndef BLOCK_MEM_PKG_MACROS
`define BLOCK_MEM_PKG_MACROS

`define BLOCK_MEM_PKT_WIDTH(addr_w, data_w) \
    (block_mem_pkg::opcode_width_lp + (addr_w) + (data_w) + ((data_w) / 8))

`define DECLARE_BLOCK_MEM_PKT_S(addr_w, data_w) \
    typedef struct packed { \
        block_mem_pkg::block_mem_opcode_e opcode; \
        logic [(addr_w)-1:0]              addr; \
        logic [(data_w)-1:0]              data; \
        logic [((data_w)/8)-1:0]          mask; \
    } block_mem_pkt_s

`endif

package block_mem_pkg;

    localparam int opcode_width_lp = 3;

    // Encoding value 7 is unused and is reported as an illegal opcode.
    typedef enum logic [opcode_width_lp-1:0] {
        e_nop   = 3'd0,
        e_lw    = 3'd1,
        e_lh    = 3'd2,
        e_lhu   = 3'd3,
        e_lb    = 3'd4,
        e_lbu   = 3'd5,
        e_store = 3'd6
    } block_mem_opcode_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_manycore_block_mem_load_align.sv
// Purely combinational load-result formatter.
//   word_i   : raw word read from the array
//   opcode_i : load opcode that produced the word
//   offset_i : byte offset within the word
//   data_o   : selected lane, sign- or zero-extended as the opcode requires
module bsg_manycore_block_mem_load_align
    import block_mem_pkg::*;
(
    input  logic [31:0]       word_i,
    input  block_mem_opcode_e opcode_i,
    input  logic [1:0]        offset_i,
    output logic [31:0]       data_o
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    assign half = offset_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
    end

    always_comb begin
        case (opcode_i)
            e_lh:    data_o = {{16{half[15]}}, half};
            e_lhu:   data_o = {16'd0, half};
            e_lb:    data_o = {{24{byte_sel[7]}}, byte_sel};
            e_lbu:   data_o = {24'd0, byte_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables.
//   clk_i        : clock
//   v_i          : access enable this cycle
//   w_i          : 1 = write, 0 = read
//   addr_i       : word address
//   data_i       : write data (lane aligned)
//   write_mask_i : byte-lane write enables
//   data_o       : registered read data; holds until the next read
module bsg_mem_1rw_sync_mask_write_byte
    import block_mem_pkg::*;
#(
    parameter int els_p       = 512,
    parameter int width_p     = 32,
    localparam int addr_width_lp = safe_clog2(els_p),
    localparam int lanes_lp      = width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [lanes_lp-1:0]      write_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem [els_p];
    logic [width_p-1:0] rd_reg;

    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int i = 0; i < lanes_lp; i++) begin
                if (write_mask_i[i]) begin
                    mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
        if (v_i && !w_i) begin
            rd_reg <= mem[addr_i];
        end
    end

    assign data_o = rd_reg;

endmodule

// File: rtl/bsg_manycore_block_mem.sv
// Block-mem packet executor: single-port byte-maskable word memory.
//   clk_i   : clock
//   reset_i : synchronous active-high reset (array contents are kept)
//   pkt_i   : {opcode, byte addr, data, mask}
//   v_i     : pkt_i valid
//   data_o  : load result, valid the cycle after the load; held otherwise
//   err_o   : sticky flag for out-of-range addresses and illegal opcodes
module bsg_manycore_block_mem
    import block_mem_pkg::*;
#(
    parameter int data_width_p        = 32,
    parameter int mem_size_in_words_p = 512,
    localparam int mem_addr_width_lp      = safe_clog2(mem_size_in_words_p) + 2,
    localparam int block_mem_pkt_width_lp = `BLOCK_MEM_PKT_WIDTH(mem_addr_width_lp, data_width_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [block_mem_pkt_width_lp-1:0] pkt_i,
    input  logic                              v_i,
    output logic [data_width_p-1:0]           data_o,
    output logic                              err_o
);

    localparam int idx_width_lp = mem_addr_width_lp - 2;

    `DECLARE_BLOCK_MEM_PKT_S(mem_addr_width_lp, data_width_p);

    block_mem_pkt_s pkt;
    assign pkt = block_mem_pkt_s'(pkt_i);

    logic [idx_width_lp-1:0] word_idx;
    logic [1:0]              offset;
    logic                    in_range;
    assign word_idx = pkt.addr[mem_addr_width_lp-1:2];
    assign offset   = pkt.addr[1:0];
    // Widened compare: the index field can exceed the array when the size
    // is not a power of two.
    assign in_range = 32'(word_idx) < 32'(mem_size_in_words_p);

    logic is_load, is_store, is_illegal;
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_illegal = 1'b0;
        case (pkt.opcode)
            e_nop:                           ;
            e_lw, e_lh, e_lhu, e_lb, e_lbu:  is_load = 1'b1;
            e_store:                         is_store = 1'b1;
            default:                         is_illegal = 1'b1;
        endcase
    end

    logic accept, load_accept, err_event;
    assign accept      = v_i & ~reset_i;
    assign load_accept = accept & is_load;
    assign err_event   = accept & (is_illegal | ((is_load | is_store) & ~in_range));

    logic [data_width_p-1:0] mem_data;
    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p   (mem_size_in_words_p),
        .width_p (data_width_p)
    ) mem (
        .clk_i        (clk_i),
        .v_i          (accept & in_range & (is_load | is_store)),
        .w_i          (is_store),
        .addr_i       (word_idx),
        .data_i       (pkt.data),
        .write_mask_i (pkt.mask),
        .data_o       (mem_data)
    );

    // zero_reg forces data_o to 0 after reset or an out-of-range load; the RAM
    // output register itself is not reset and is only updated by real reads.
    block_mem_opcode_e op_reg, op_next;
    logic [1:0]        off_reg, off_next;
    logic              zero_reg, zero_next;
    logic              err_reg, err_next;

    always_comb begin
        op_next   = op_reg;
        off_next  = off_reg;
        zero_next = zero_reg;
        err_next  = err_reg | err_event;
        if (load_accept) begin
            op_next   = pkt.opcode;
            off_next  = offset;
            zero_next = ~in_range;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_reg   <= e_lw;
            off_reg  <= 2'd0;
            zero_reg <= 1'b1;
            err_reg  <= 1'b0;
        end else begin
            op_reg   <= op_next;
            off_reg  <= off_next;
            zero_reg <= zero_next;
            err_reg  <= err_next;
        end
    end

    logic [data_width_p-1:0] aligned;
    bsg_manycore_block_mem_load_align align (
        .word_i   (mem_data),
        .opcode_i (op_reg),
        .offset_i (off_reg),
        .data_o   (aligned)
    );

    assign data_o = zero_reg ? '0 : aligned;
    assign err_o  = err_reg;

endmodule

// File: tb/tb_bsg_manycore_block_mem.sv
// Directed bench for bsg_manycore_block_mem (20-word array, 7-bit byte address).
module tb_bsg_manycore_block_mem;

    localparam int SIZE = 20;
    localparam int AW   = 7;
    localparam int PW   = 3 + AW + 32 + 4;

    localparam logic [2:0] NOP = 3'd0, LW = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LB = 3'd4, LBU = 3'd5, ST = 3'd6, BAD = 3'd7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] pkt = '0;
    logic          v = 1'b0;
    logic [31:0]   data_o;
    logic          err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bsg_manycore_block_mem #(
        .data_width_p        (32),
        .mem_size_in_words_p (SIZE)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .pkt_i   (pkt),
        .v_i     (v),
        .data_o  (data_o),
        .err_o   (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Present one op for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
        pkt = {op, addr, data, mask};
        v   = 1'b1;
        @(posedge clk);
        #1;
        v   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] amo;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        check("reset_data", data_o, 32'h0);
        check("reset_err", {31'd0, err_o}, 32'h0);

        // word store / load
        issue(ST, 7'h10, 32'hDEADBEEF, 4'b1111);
        issue(LW, 7'h10, 32'h0, 4'b0);
        check("lw_word", data_o, 32'hDEADBEEF);

        // byte / half extension
        issue(ST, 7'h20, 32'h80FF7F01, 4'b1111);
        issue(LB, 7'h23, 32'h0, 4'b0);
        check("lb_neg", data_o, 32'hFFFFFF80);
        issue(LBU, 7'h23, 32'h0, 4'b0);
        check("lbu", data_o, 32'h00000080);
        issue(LB, 7'h21, 32'h0, 4'b0);
        check("lb_pos", data_o, 32'h0000007F);
        issue(LH, 7'h20, 32'h0, 4'b0);
        check("lh_lo", data_o, 32'h00007F01);
        issue(LH, 7'h22, 32'h0, 4'b0);
        check("lh_hi_neg", data_o, 32'hFFFF80FF);
        issue(LHU, 7'h22, 32'h0, 4'b0);
        check("lhu_hi", data_o, 32'h000080FF);
        issue(LW, 7'h23, 32'h0, 4'b0);
        check("lw_ignores_offset", data_o, 32'h80FF7F01);

        // masked stores
        issue(ST, 7'h30, 32'h11223344, 4'b1111);
        issue(ST, 7'h30, 32'hAABBCCDD, 4'b0101);
        issue(LW, 7'h30, 32'h0, 4'b0);
        check("mask_0101", data_o, 32'h11BB33DD);
        issue(ST, 7'h30, 32'h00000000, 4'b0000);
        issue(LW, 7'h30, 32'h0, 4'b0);
        check("mask_0000", data_o, 32'h11BB33DD);

        // AMO read-then-write with hold
        issue(ST, 7'h40, 32'd5, 4'b1111);
        issue(LW, 7'h40, 32'h0, 4'b0);
        check("amo_load", data_o, 32'd5);
        issue(NOP, 7'h00, 32'h0, 4'b0);
        check("amo_hold_nop", data_o, 32'd5);
        amo = data_o + 32'd3;
        issue(ST, 7'h40, amo, 4'b1111);
        check("amo_hold_store", data_o, 32'd5);
        idle();
        check("amo_hold_idle", data_o, 32'd5);
        issue(LW, 7'h40, 32'h0, 4'b0);
        check("amo_result", data_o, 32'd8);

        // back-to-back loads and store-then-load
        issue(ST, 7'h00, 32'h0000000A, 4'b1111);
        issue(ST, 7'h04, 32'h0000000B, 4'b1111);
        issue(ST, 7'h08, 32'h0000000C, 4'b1111);
        issue(LW, 7'h00, 32'h0, 4'b0);
        check("b2b_0", data_o, 32'h0000000A);
        issue(LW, 7'h04, 32'h0, 4'b0);
        check("b2b_1", data_o, 32'h0000000B);
        issue(LW, 7'h08, 32'h0, 4'b0);
        check("b2b_2", data_o, 32'h0000000C);
        issue(ST, 7'h0C, 32'h00001234, 4'b1111);
        issue(LW, 7'h0C, 32'h0, 4'b0);
        check("store_then_load", data_o, 32'h00001234);
        check("no_err_yet", {31'd0, err_o}, 32'h0);

        // out-of-range load: word index 20
        issue(LW, 7'h50, 32'h0, 4'b0);
        check("oob_data", data_o, 32'h0);
        check("oob_err", {31'd0, err_o}, 32'h1);
        issue(LW, 7'h10, 32'h0, 4'b0);
        check("err_sticky", {31'd0, err_o}, 32'h1);
        check("load_after_oob", data_o, 32'hDEADBEEF);

        // reset right after a load discards its result; store in reset ignored
        issue(LW, 7'h20, 32'h0, 4'b0);
        reset = 1'b1;
        pkt   = {ST, 7'h10, 32'h00000000, 4'b1111};
        v     = 1'b1;
        @(posedge clk);
        #1;
        v     = 1'b0;
        reset = 1'b0;
        check("reset_clears_data", data_o, 32'h0);
        check("reset_clears_err", {31'd0, err_o}, 32'h0);
        issue(LW, 7'h10, 32'h0, 4'b0);
        check("store_in_reset_ignored", data_o, 32'hDEADBEEF);

        // illegal opcode flags error and does not disturb data_o
        issue(BAD, 7'h10, 32'h0, 4'b1111);
        check("illegal_err", {31'd0, err_o}, 32'h1);
        check("illegal_hold", data_o, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
